// File: rtl/muldiv_if.sv
// Execute-stage handshake between the datapath and the iterative multiply/divide unit.
interface muldiv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Start;
    logic [2:0]            Operation;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  Busy;
    logic                  Done;
    logic [DATA_WIDTH-1:0] Result;

    modport master (output Start, Operation, SrcA, SrcB, input Busy, Done, Result);
    modport slave  (input Start, Operation, SrcA, SrcB, output Busy, Done, Result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, fixed DATA_WIDTH+3 cycle turnaround, sign fix-up in a final FIX cycle.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [W-1:0]    a_q, b_q, mag_a, mag_b, quo, rem, result;
    logic [2*W-1:0]  prod;
    logic            neg_res, neg_rem, busy, done;

    // operand sign handling, evaluated on the raw inputs at the Start cycle
    logic            a_sgn, b_sgn, sa, sb;
    logic [W-1:0]    mag_a_in, mag_b_in;

    always_comb begin
        a_sgn    = bus.Operation inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
        b_sgn    = bus.Operation inside {3'b000, 3'b001, 3'b100, 3'b110};
        sa       = a_sgn & bus.SrcA[W-1];
        sb       = b_sgn & bus.SrcB[W-1];
        mag_a_in = sa ? -bus.SrcA : bus.SrcA;
        mag_b_in = sb ? -bus.SrcB : bus.SrcB;
    end

    // one iteration of each algorithm; both advance every CALC cycle, FIX picks the one needed
    logic [W:0]      mul_sum, div_sh;
    logic [W-1:0]    rem_trial;
    logic            div_ok;

    always_comb begin
        mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mag_a} : '0);
        div_sh    = {rem, quo[W-1]};
        div_ok    = div_sh >= {1'b0, mag_b};
        rem_trial = div_sh[W-1:0] - mag_b;
    end

    logic [2*W-1:0]  prod_s;
    logic [W-1:0]    quo_s, rem_s, fix_res;
    logic            div0, ovf;

    always_comb begin
        prod_s  = neg_res ? -prod : prod;
        quo_s   = neg_res ? -quo : quo;
        rem_s   = neg_rem ? -rem : rem;
        div0    = (b_q == '0);
        ovf     = (op_q == 3'b100 || op_q == 3'b110) &&
                  (a_q == {1'b1, {(W-1){1'b0}}}) && (b_q == '1);
        fix_res = '0;
        case (op_q)
            3'b000:                 fix_res = prod_s[W-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*W-1:W];
            3'b100, 3'b101:         fix_res = div0 ? '1 : (ovf ? {1'b1, {(W-1){1'b0}}} : quo_s);
            default:                fix_res = div0 ? a_q : (ovf ? '0 : rem_s);
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.Start) state_n = CALC;
            CALC:    if (cnt == CW'(W-1)) state_n = FIX;
            FIX:     state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            prod    <= '0;
            quo     <= '0;
            rem     <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n == CALC) || (state_n == FIX);
            done  <= (state_n == DONE);
            case (state)
                IDLE: if (bus.Start) begin
                    cnt     <= '0;
                    op_q    <= bus.Operation;
                    a_q     <= bus.SrcA;
                    b_q     <= bus.SrcB;
                    mag_a   <= mag_a_in;
                    mag_b   <= mag_b_in;
                    neg_res <= sa ^ sb;
                    neg_rem <= sa;
                    prod    <= {{W{1'b0}}, mag_b_in};
                    quo     <= mag_a_in;
                    rem     <= '0;
                end
                CALC: begin
                    cnt  <= cnt + 1'b1;
                    prod <= {mul_sum, prod[W-1:1]};
                    quo  <= {quo[W-2:0], div_ok};
                    rem  <= div_ok ? rem_trial : div_sh[W-1:0];
                end
                FIX:     result <= fix_res;
                default: ;
            endcase
        end
    end

    assign bus.Busy   = busy;
    assign bus.Done   = done;
    assign bus.Result = result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, corner sequences, and randomized ops
// checked against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.DATA_WIDTH(32)) bus ();
    muldiv_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issues one op; lat = negedge count after the Start edge at which Done is seen (-1 on timeout).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit poke, output logic [31:0] res, output int lat,
                          output int busy_err);
        @(negedge clk);
        bus.Start = 1'b1; bus.Operation = op; bus.SrcA = a; bus.SrcB = b;
        @(negedge clk);
        bus.Start = 1'b0;
        lat = -1; busy_err = 0; res = 'x;
        for (int n = 1; n <= 60; n++) begin
            if (poke && n == 5) begin
                bus.Start = 1'b1; bus.Operation = ~op;
                bus.SrcA = $urandom; bus.SrcB = $urandom;
            end
            if (poke && n == 6) bus.Start = 1'b0;
            if (bus.Done === 1'b1) begin
                lat = n; res = bus.Result;
                if (bus.Busy !== 1'b0) busy_err++;
                break;
            end
            if (bus.Busy !== 1'(n <= 33)) busy_err++;
            @(negedge clk);
        end
    endtask

    task automatic op_check(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input bit poke);
        logic [31:0] res;
        int lat, be;
        run_op(op, a, b, poke, res, lat, be);
        check({name, " result"}, res, exp);
        check({name, " latency"}, 32'(lat), 32'd34);
        check({name, " busy profile errors"}, 32'(be), 32'd0);
    endtask

    task automatic watch_no_done(input string name, input int cycles, input logic [31:0] hold);
        int dones = 0, changes = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.Done !== 1'b0) dones++;
            if (bus.Result !== hold) changes++;
        end
        check({name, " stray Done count"}, 32'(dones), 32'd0);
        check({name, " Result changes"}, 32'(changes), 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, res;
        int          r;

        reset = 1'b0;
        bus.Start = 1'b0; bus.Operation = '0; bus.SrcA = '0; bus.SrcB = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset Busy", {31'b0, bus.Busy}, 32'd0);
        check("reset Done", {31'b0, bus.Done}, 32'd0);
        check("reset Result", bus.Result, 32'd0);
        reset = 1'b1;

        vecs.push_back('{3'd0, 32'd7,          32'd6,          32'd42,         "MUL 7x6"});
        vecs.push_back('{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   "MULH -1x-1"});
        vecs.push_back('{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   "MULHU max"});
        vecs.push_back('{3'd2, 32'hFFFFFFFF,   32'h00000002,   32'hFFFFFFFF,   "MULHSU -1x2"});
        vecs.push_back('{3'd0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   "MUL -1x-1"});
        vecs.push_back('{3'd3, 32'h80000000,   32'h00000002,   32'h00000001,   "MULHU 2^31x2"});
        vecs.push_back('{3'd4, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   "DIV -7/2"});
        vecs.push_back('{3'd6, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   "REM -7/2"});
        vecs.push_back('{3'd5, 32'd100,        32'd7,          32'd14,         "DIVU 100/7"});
        vecs.push_back('{3'd7, 32'd100,        32'd7,          32'd2,          "REMU 100/7"});
        vecs.push_back('{3'd4, 32'd5,          32'd0,          32'hFFFFFFFF,   "DIV 5/0"});
        vecs.push_back('{3'd7, 32'd5,          32'd0,          32'd5,          "REMU 5/0"});
        vecs.push_back('{3'd5, 32'd5,          32'd0,          32'hFFFFFFFF,   "DIVU 5/0"});
        vecs.push_back('{3'd6, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   "REM -5/0"});
        vecs.push_back('{3'd4, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   "DIV overflow"});
        vecs.push_back('{3'd6, 32'h80000000,   32'hFFFFFFFF,   32'h00000000,   "REM overflow"});

        // back-to-back issue: each Start lands in the cycle right after the previous Done
        foreach (vecs[i]) op_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);

        // Start and operand changes during CALC must not disturb the running op
        op_check("MUL with poke", 3'd0, 32'd12345, 32'd678, 32'd8369910, 1'b1);
        watch_no_done("after poke", 40, 32'd8369910);

        // reset in the middle of a DIVU
        @(negedge clk);
        bus.Start = 1'b1; bus.Operation = 3'd5; bus.SrcA = 32'd1000; bus.SrcB = 32'd3;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid reset Busy", {31'b0, bus.Busy}, 32'd0);
        check("mid reset Done", {31'b0, bus.Done}, 32'd0);
        check("mid reset Result", bus.Result, 32'd0);
        reset = 1'b1;
        watch_no_done("after mid reset", 45, 32'd0);
        op_check("MUL 3x3 after reset", 3'd0, 32'd3, 32'd3, 32'd9, 1'b0);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            if (r == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if (r == 2) b = 32'($urandom_range(1, 20));
            if (r == 3) a = 32'($urandom_range(0, 50));
            res = ref_model(op, a, b);
            op_check($sformatf("rand%0d op%0d %h/%h", i, op, a, b), op, a, b, res, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
